// File: rtl/bcd_code_decoder.sv
// bcd_code_decoder: packed BCD OTP code to binary via reverse double-dabble, flags non-decimal digits
module bcd_code_decoder #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic [4*DIGITS-1:0] bcd_code,
  output logic [BIN_W-1:0]    bin_value,
  output logic                ready,
  output logic                bad_digit
);
  localparam int CW = $clog2(BIN_W);
  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [4*DIGITS-1:0] sr_bcd, bcd_nx;
  logic [BIN_W-1:0]    sr_bin, bin_nx;
  logic [CW-1:0]       cnt;
  logic                bad, last;
  // One reverse double-dabble step: shift right, then pull every nibble >= 8 back by 3
  always_comb begin
    {bcd_nx, bin_nx} = {sr_bcd, sr_bin} >> 1;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (sr_bcd[4*i +: 4] > 4'd9);
      bcd_nx[4*i +: 4] = (bcd_nx[4*i +: 4] >= 4'd8) ? bcd_nx[4*i +: 4] - 4'd3 : bcd_nx[4*i +: 4];
    end
  end
  assign last = (cnt == CW'(BIN_W - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = (state == IDLE)  ? (init ? CHECK : IDLE) :
               (state == CHECK) ? (bad ? IDLE : SHIFT) :
               (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr_bcd    <= '0;
      sr_bin    <= '0;
      cnt       <= '0;
      bin_value <= '0;
      ready     <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (init) begin
            sr_bcd    <= bcd_code;
            sr_bin    <= '0;
            ready     <= 1'b0;
            bad_digit <= 1'b0;
          end else ready <= 1'b1;
        CHECK:
          if (bad) begin
            bad_digit <= 1'b1;
            bin_value <= '0;
            ready     <= 1'b1;
          end else cnt <= '0;
        SHIFT: begin
          sr_bcd <= bcd_nx;
          sr_bin <= bin_nx;
          cnt    <= cnt + 1'b1;
        end
        DONE: begin
          bin_value <= sr_bin;
          ready     <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bcd_code_decoder.sv
// tb_bcd_code_decoder: table-driven vectors plus hand-written corner sequences, scoreboard queue
module tb_bcd_code_decoder;
  logic        clk = 1'b0, rst_n = 1'b1, init = 1'b0;
  logic [23:0] bcd_code = '0;
  logic [19:0] bin_value;
  logic        ready, bad_digit;
  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  typedef struct {logic [19:0] bin; logic bad; int lat;} exp_t;
  typedef struct {logic [23:0] bcd; logic [19:0] bin; logic bad;} vec_t;
  exp_t sb[$];
  vec_t vec[9];
  bcd_code_decoder dut (
    .clk(clk), .rst_n(rst_n), .init(init), .bcd_code(bcd_code),
    .bin_value(bin_value), .ready(ready), .bad_digit(bad_digit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic start(input logic [23:0] c, input logic [19:0] b, input logic bad, input bit hold);
    @(negedge clk);
    init = 1'b1;
    bcd_code = c;
    sb.push_back('{b, bad, bad ? 1 : 22});
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!hold) init = 1'b0;
    chk("busy_ready", {31'd0, ready}, 0);
    chk("bad_clear", {31'd0, bad_digit}, 0);
  endtask
  task automatic wait_done();
    exp_t e;
    do begin
      @(posedge clk);
      #1;
    end while (!ready && cyc - t0 < 60);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: result with no pending request");
    end else begin
      e = sb.pop_front();
      chk("latency", cyc - t0, e.lat);
      chk("bin_value", {12'd0, bin_value}, {12'd0, e.bin});
      chk("bad_digit", {31'd0, bad_digit}, {31'd0, e.bad});
    end
  endtask
  initial begin
    vec[0] = '{24'h999999, 20'hF423F, 1'b0};
    vec[1] = '{24'h123456, 20'h1E240, 1'b0};
    vec[2] = '{24'h000000, 20'h00000, 1'b0};
    vec[3] = '{24'h12A456, 20'h00000, 1'b1};
    vec[4] = '{24'h100000, 20'h186A0, 1'b0};
    vec[5] = '{24'h00000F, 20'h00000, 1'b1};
    vec[6] = '{24'h000010, 20'h0000A, 1'b0};
    vec[7] = '{24'hF00000, 20'h00000, 1'b1};
    vec[8] = '{24'h090807, 20'h162B7, 1'b0};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_bin", {12'd0, bin_value}, 0);
    chk("rst_bad", {31'd0, bad_digit}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", {31'd0, ready}, 1);
    for (int i = 0; i < 9; i++) begin
      start(vec[i].bcd, vec[i].bin, vec[i].bad, 1'b0);
      wait_done();
    end
    // async reset while idle with a nonzero result held
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("idle_rst_ready", {31'd0, ready}, 0);
    chk("idle_rst_bin", {12'd0, bin_value}, 0);
    chk("idle_rst_bad", {31'd0, bad_digit}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_rst_ready_back", {31'd0, ready}, 1);
    // init re-pulsed during SHIFT must be ignored
    start(24'h123456, 20'h1E240, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    init = 1'b1;
    bcd_code = 24'h999999;
    @(negedge clk) init = 1'b0;
    wait_done();
    // reset mid-SHIFT
    start(24'h999999, 20'hF423F, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("shift_rst_ready", {31'd0, ready}, 0);
    chk("shift_rst_bin", {12'd0, bin_value}, 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("shift_rst_idle", {31'd0, ready}, 1);
    start(24'h000042, 20'h0002A, 1'b0, 1'b0);
    wait_done();
    // init held high across three back-to-back requests
    start(24'h000001, 20'h00001, 1'b0, 1'b1);
    wait_done();
    bcd_code = 24'h500000;
    sb.push_back('{20'h7A120, 1'b0, 22});
    @(posedge clk);
    #1 t0 = cyc;
    chk("b2b_gap1", {31'd0, ready}, 0);
    wait_done();
    bcd_code = 24'h999998;
    sb.push_back('{20'hF423E, 1'b0, 22});
    @(posedge clk);
    #1 t0 = cyc;
    init = 1'b0;
    chk("b2b_gap2", {31'd0, ready}, 0);
    wait_done();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
